athos_obi_stream_reader: RTL

- OBI initiator that fills the external-xbar master slot of the accelerator subsystem; that slot is currently tied off.
- Fetches a contiguous block of 32-bit words from X-HEEP memory and delivers them in order on a valid/ready stream, for example polynomial coefficients into the NTT/INTT core.
- Software or the accelerator register file supplies the source address and length and pulses start.
- Completion is signalled by a one-cycle pulse that is usable as an interrupt source.

---
 rtl/athos_obi_stream_reader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/athos_obi_stream_reader.sv
// Purpose: OBI read initiator that fetches len 32-bit words from src_addr and streams them out in order.
// Latency: first stream beat is visible one cycle after its rvalid (registered FIFO, no bypass).
// Backpressure: m_ready_i stalls drain the FIFO; new requests are withheld until every response has a FIFO slot.
module athos_obi_stream_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             obi_req_o,
    output logic             obi_we_o,
    output logic [3:0]       obi_be_o,
    output logic [31:0]      obi_addr_o,
    output logic [31:0]      obi_wdata_o,
    input  logic             obi_gnt_i,
    input  logic             obi_rvalid_i,
    input  logic [31:0]      obi_rdata_i,
    output logic             m_valid_o,
    output logic [31:0]      m_data_o,
    output logic             m_last_o,
    input  logic             m_ready_i
);

    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW  = AW + 1;      // holds 0..FIFO_DEPTH
    localparam int CRW = OW + 1;      // outstanding + fifo count
    localparam int CW  = LEN_W + 1;   // word counters, room for a full 2^LEN_W-1 count

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q;
    logic [CW-1:0]    len_q, issued_q, delivered_q;
    logic [OW-1:0]    outstanding_q, fifo_cnt_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [31:0]      mem_q [FIFO_DEPTH];

    logic             active, start_acc, gnt_acc, rsp_acc, pop, fifo_empty, last_word, req;
    logic [CRW-1:0]   credit_used;
    logic             unused_addr_lsb;

    // Low address bits are forced to zero on latch; keep them visibly consumed.
    assign unused_addr_lsb = ^src_addr_i[1:0];

    assign active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign start_acc   = (state_q == ST_IDLE) && start_i;
    assign credit_used = CRW'(outstanding_q) + CRW'(fifo_cnt_q);
    // Issue only while a FIFO slot is reserved for the response: OBI cannot stall rvalid.
    assign req         = (state_q == ST_RUN) && (issued_q < len_q) && (credit_used < CRW'(FIFO_DEPTH));
    assign gnt_acc     = req && obi_gnt_i;
    // Responses outside an active transfer (e.g. in flight across a reset) are dropped.
    assign rsp_acc     = active && obi_rvalid_i && (outstanding_q != '0);
    assign fifo_empty  = (fifo_cnt_q == '0);
    assign pop         = !fifo_empty && m_ready_i;
    assign last_word   = (delivered_q == len_q - CW'(1));

    assign busy_o      = active;
    assign done_o      = (state_q == ST_DONE);
    assign obi_req_o   = req;
    assign obi_we_o    = 1'b0;
    assign obi_be_o    = 4'hF;
    assign obi_addr_o  = addr_q;
    assign obi_wdata_o = '0;
    assign m_valid_o   = !fifo_empty;
    assign m_data_o    = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign m_last_o    = !fifo_empty && last_word;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state: a zero-length start completes without touching the bus.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = (len_i == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (gnt_acc && (issued_q == len_q - CW'(1))) state_d = ST_DRAIN;
            ST_DRAIN: if (pop && last_word) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Transfer parameters, address generator and word counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
        end else if (start_acc) begin
            addr_q      <= {src_addr_i[31:2], 2'b00};
            len_q       <= CW'(len_i);
            issued_q    <= '0;
            delivered_q <= '0;
        end else begin
            if (gnt_acc) begin
                addr_q   <= addr_q + 32'd4;
                issued_q <= issued_q + CW'(1);
            end
            if (pop) delivered_q <= delivered_q + CW'(1);
        end
    end

    // Outstanding requests: grant adds one, accepted response retires one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            case ({gnt_acc, rsp_acc})
                2'b10:   outstanding_q <= outstanding_q + OW'(1);
                2'b01:   outstanding_q <= outstanding_q - OW'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (rsp_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            if (rsp_acc && !pop)      fifo_cnt_q <= fifo_cnt_q + OW'(1);
            else if (pop && !rsp_acc) fifo_cnt_q <= fifo_cnt_q - OW'(1);
        end
    end

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (rsp_acc) mem_q[wr_ptr_q] <= obi_rdata_i;
    end

endmodule
